// File: rtl/jk_bank_arbiter_pkg.sv
// Shared types for the JK bank arbiter: operation encoding and FSM states.
package jk_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_CLR  = 2'b01,
    OP_SET  = 2'b10,
    OP_TOG  = 2'b11
  } jk_op_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_APPLY = 2'b01,
    S_RESP  = 2'b10
  } arb_state_t;

endpackage

// File: rtl/jk_bank_arbiter_if.sv
// Request/response bus between command sources and the JK bank arbiter.
interface jk_bank_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int CNTW  = 4
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*2-1:0]     req_op;
  logic [NREQ*WIDTH-1:0] req_mask;
  logic [NREQ*CNTW-1:0]  req_rpt;
  logic                  rsp_valid;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_q;

  modport master (
    output req_valid, req_op, req_mask, req_rpt,
    input  req_ready, rsp_valid, rsp_id, rsp_q
  );

  modport slave (
    input  req_valid, req_op, req_mask, req_rpt,
    output req_ready, rsp_valid, rsp_id, rsp_q
  );
endinterface

// File: rtl/jk_bank_arbiter_jk_bank.sv
// Bank of WIDTH JK flip-flops with synchronous clear; qbar is kept as its own register.
module jk_bank #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar
);
  logic [WIDTH-1:0] q_next_s;

  // JK characteristic equation: q+ = j&~q | ~k&q
  always_comb begin
    q_next_s = (j & ~q) | (~k & q);
  end

  // Storage update for the bank and its complement
  always_ff @(posedge clk) begin
    if (rst) begin
      q    <= '0;
      qbar <= '1;
    end else begin
      q    <= q_next_s;
      qbar <= ~q_next_s;
    end
  end
endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter that applies one requester's JK op to a shared bank rpt+1 times, then responds.
module jk_bank_arbiter
  import jk_ctrl_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int CNTW  = 4
) (
  input  logic               clk,
  input  logic               rst,
  jk_bank_arbiter_if.slave   bus,
  output logic [WIDTH-1:0]   q,
  output logic [WIDTH-1:0]   qbar,
  output logic               busy
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_t        state_r;
  arb_state_t        state_s;
  logic [IDW-1:0]    rr_ptr_r;
  jk_op_t            op_r;
  logic [WIDTH-1:0]  mask_r;
  logic [CNTW-1:0]   cnt_r;
  logic [IDW-1:0]    id_r;
  logic              grant_found_s;
  logic [IDW-1:0]    grant_idx_s;
  logic              handshake_s;
  logic [WIDTH-1:0]  j_s;
  logic [WIDTH-1:0]  k_s;

  // First valid requester at or after rr_ptr, wrapping modulo NREQ
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    for (int i = 0; i < NREQ; i++) begin
      int             cand;
      logic [IDW-1:0] cand_idx;
      cand     = int'(rr_ptr_r) + i;
      cand     = (cand >= NREQ) ? (cand - NREQ) : cand;
      cand_idx = IDW'(cand);
      if (!grant_found_s && bus.req_valid[cand_idx]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = cand_idx;
      end else begin
        grant_found_s = grant_found_s;
        grant_idx_s   = grant_idx_s;
      end
    end
  end

  assign handshake_s = (state_r == S_IDLE) && grant_found_s;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (handshake_s) state_s = S_APPLY;
        else             state_s = S_IDLE;
      end
      S_APPLY: begin
        if (cnt_r == CNTW'(0)) state_s = S_RESP;
        else                   state_s = S_APPLY;
      end
      S_RESP:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // FSM outputs: grant, bank drive and response
  always_comb begin
    bus.req_ready = '0;
    j_s           = '0;
    k_s           = '0;
    bus.rsp_valid = 1'b0;
    bus.rsp_id    = '0;
    bus.rsp_q     = '0;
    busy          = 1'b1;
    case (state_r)
      S_IDLE: begin
        busy                       = 1'b0;
        bus.req_ready[grant_idx_s] = grant_found_s;
      end
      S_APPLY: begin
        j_s = op_r[1] ? mask_r : '0;
        k_s = op_r[0] ? mask_r : '0;
      end
      S_RESP: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_id    = id_r;
        bus.rsp_q     = q;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Command latch, repeat counter and rotation pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_r <= '0;
      op_r     <= OP_HOLD;
      mask_r   <= '0;
      cnt_r    <= '0;
      id_r     <= '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (handshake_s) begin
            op_r     <= jk_op_t'(bus.req_op[int'(grant_idx_s)*2 +: 2]);
            mask_r   <= bus.req_mask[int'(grant_idx_s)*WIDTH +: WIDTH];
            cnt_r    <= bus.req_rpt[int'(grant_idx_s)*CNTW +: CNTW];
            id_r     <= grant_idx_s;
            rr_ptr_r <= (grant_idx_s == IDW'(NREQ-1)) ? IDW'(0) : grant_idx_s + IDW'(1);
          end else begin
            rr_ptr_r <= rr_ptr_r;
          end
        end
        S_APPLY: begin
          if (cnt_r != CNTW'(0)) cnt_r <= cnt_r - CNTW'(1);
          else                   cnt_r <= cnt_r;
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  jk_bank #(.WIDTH(WIDTH)) u_bank (
    .clk  (clk),
    .rst  (rst),
    .j    (j_s),
    .k    (k_s),
    .q    (q),
    .qbar (qbar)
  );
endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Directed self-checking bench for jk_bank_arbiter with hand-computed expectations.
module tb_jk_bank_arbiter;
  logic       clk;
  logic       rst;
  logic [7:0] q;
  logic [7:0] qbar;
  logic       busy;
  int         n_checks;
  int         n_fail;

  jk_bank_arbiter_if #(.NREQ(4), .WIDTH(8), .CNTW(4)) bus ();

  jk_bank_arbiter #(.NREQ(4), .WIDTH(8), .CNTW(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .q    (q),
    .qbar (qbar),
    .busy (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one command from requester idx, starting just after a negedge in IDLE
  task automatic run_cmd(input string tag, input int idx, input logic [1:0] op,
                         input logic [7:0] mask, input logic [3:0] rpt, input logic [7:0] exp_q);
    int         lat;
    logic [3:0] onehot;
    onehot      = 4'b0000;
    onehot[idx] = 1'b1;
    bus.req_op[idx*2 +: 2]   = op;
    bus.req_mask[idx*8 +: 8] = mask;
    bus.req_rpt[idx*4 +: 4]  = rpt;
    bus.req_valid            = onehot;
    #1;
    check_eq({tag, "_ready"}, 32'(bus.req_ready), 32'(onehot));
    @(negedge clk);
    bus.req_valid = 4'b0000;
    check_eq({tag, "_busy"}, 32'(busy), 32'd1);
    lat = 1;
    while (!bus.rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check_eq({tag, "_lat"}, 32'(lat), 32'(rpt) + 32'd2);
    check_eq({tag, "_id"}, 32'(bus.rsp_id), 32'(idx));
    check_eq({tag, "_rspq"}, 32'(bus.rsp_q), 32'(exp_q));
    check_eq({tag, "_q"}, 32'(q), 32'(exp_q));
    @(negedge clk);
    check_eq({tag, "_idle"}, 32'(busy), 32'd0);
    check_eq({tag, "_rspoff"}, 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    int         seen_rsp;
    logic [3:0] exp_g;
    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.req_valid = 4'b0000;
    bus.req_op    = 8'h00;
    bus.req_mask  = 32'h0000_0000;
    bus.req_rpt   = 16'h0000;

    // 1: reset for two cycles
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst_q", 32'(q), 32'h00);
    check_eq("rst_qbar", 32'(qbar), 32'hFF);
    check_eq("rst_ready", 32'(bus.req_ready), 32'h0);
    check_eq("rst_rspv", 32'(bus.rsp_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_rspid", 32'(bus.rsp_id), 32'd0);
    check_eq("rst_rspq", 32'(bus.rsp_q), 32'h00);
    @(negedge clk);

    // 2: req0 SET 0F once
    run_cmd("set0", 0, 2'b10, 8'h0F, 4'd0, 8'h0F);
    check_eq("set0_qbar", 32'(qbar), 32'hF0);
    // 3: req1 TOG FF three times from 0F
    run_cmd("tog1", 1, 2'b11, 8'hFF, 4'd2, 8'hF0);
    // 5: req2 CLR 3C, then req3 HOLD with empty mask
    run_cmd("clr2", 2, 2'b01, 8'h3C, 4'd0, 8'hC0);
    run_cmd("hold3", 3, 2'b00, 8'h00, 4'd0, 8'hC0);
    // SET repeated is idempotent, mask=0 TOG leaves the bank untouched
    run_cmd("setrep0", 0, 2'b10, 8'h01, 4'd15, 8'hC1);
    run_cmd("togm0", 1, 2'b11, 8'h00, 4'd1, 8'hC1);
    run_cmd("clr2b", 2, 2'b01, 8'h01, 4'd0, 8'hC0);
    run_cmd("hold3b", 3, 2'b00, 8'hFF, 4'd0, 8'hC0);

    // 4: all requesters valid with HOLD, strict rotation from pointer 0
    bus.req_op    = 8'h00;
    bus.req_rpt   = 16'h0000;
    bus.req_mask  = 32'hFFFF_FFFF;
    bus.req_valid = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      exp_g        = 4'b0000;
      exp_g[n % 4] = 1'b1;
      #1;
      check_eq($sformatf("rot%0d_ready", n), 32'(bus.req_ready), 32'(exp_g));
      @(negedge clk);
      if (n == 4) bus.req_valid = 4'b0000;
      check_eq($sformatf("rot%0d_applyrdy", n), 32'(bus.req_ready), 32'h0);
      @(negedge clk);
      check_eq($sformatf("rot%0d_rspv", n), 32'(bus.rsp_valid), 32'd1);
      check_eq($sformatf("rot%0d_id", n), 32'(bus.rsp_id), 32'(n % 4));
      check_eq($sformatf("rot%0d_rspq", n), 32'(bus.rsp_q), 32'hC0);
      @(negedge clk);
    end
    #1;
    check_eq("rot_end_busy", 32'(busy), 32'd0);

    // 6: reset during APPLY of TOG rpt=5 from requester 2 (pointer is 1)
    @(negedge clk);
    bus.req_op[4 +: 2]    = 2'b11;
    bus.req_mask[16 +: 8] = 8'hFF;
    bus.req_rpt[8 +: 4]   = 4'd5;
    bus.req_valid         = 4'b0100;
    #1;
    check_eq("rst6_ready", 32'(bus.req_ready), 32'h4);
    @(negedge clk);
    bus.req_valid = 4'b0000;
    @(negedge clk);
    check_eq("rst6_midq", 32'(q), 32'h3F);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst6_q", 32'(q), 32'h00);
    check_eq("rst6_qbar", 32'(qbar), 32'hFF);
    check_eq("rst6_busy", 32'(busy), 32'd0);
    check_eq("rst6_rspv", 32'(bus.rsp_valid), 32'd0);
    rst      = 1'b0;
    seen_rsp = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.rsp_valid) seen_rsp++;
    end
    check_eq("rst6_norsp", 32'(seen_rsp), 32'd0);
    bus.req_op    = 8'h00;
    bus.req_rpt   = 16'h0000;
    bus.req_valid = 4'b1111;
    #1;
    check_eq("rst6_regrant", 32'(bus.req_ready), 32'h1);
    @(negedge clk);
    bus.req_valid = 4'b0000;
    @(negedge clk);
    check_eq("rst6_rspv2", 32'(bus.rsp_valid), 32'd1);
    check_eq("rst6_id2", 32'(bus.rsp_id), 32'd0);
    check_eq("rst6_rspq2", 32'(bus.rsp_q), 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
